audio_adc_rx: RTL and testbench
===============================

# audio_adc_rx

Receive-side companion to the audio DAC serializer. It deserializes one 32-bit frame (left[31:16], right[15:0]) per LRCK pulse from the codec's ADC serial output. It runs entirely in the 50 MHz system clock domain, oversampling AUD_BCLK, AUD_ADCLRCK and AUD_ADCDAT. It presents each completed frame to the FIR datapath on a valid/ack handshake.

## Interface
- DATA_WIDTH, 32, bits per frame, MSB first; must be ≥ 2
- SYNC_STAGES, 2, synchronizer flops per serial input; must be ≥ 2
- clk  input  1  50 MHz system clock, rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-low
- AUD_BCLK  input  1  codec bit clock, asynchronous to clk
- AUD_ADCLRCK  input  1  codec frame strobe, high for one BCLK period before the MSB
- AUD_ADCDAT  input  1  codec serial data, stable around BCLK rising edge
- data_ack  input  1  consumer accepts data this cycle, sampled only while data_valid = 1
- data  output  DATA_WIDTH  last completed frame
- data_valid  output  1  high from frame completion until the cycle data_ack = 1
- overrun  output  1  sticky; a frame completed while the previous one was unacknowledged
- frame_err  output  1  one-clk pulse; LRCK seen high mid-frame, capture restarted

## Operation
- Each serial input passes through SYNC_STAGES flops. BCLK, LRCK and DAT use identical depth, so they stay mutually aligned.
- bclk_rise strobe is high for one clk when the synchronized BCLK is 1 and its previous value was 0. All state updates below happen only on bclk_rise cycles, except the handshake and DONE.
- FSM states: IDLE, ARM, SHIFT, DONE. Encodings outside these four are illegal and return to IDLE on the next clk.
- IDLE: on bclk_rise with LRCK = 1, go to ARM.
- ARM: on the next bclk_rise, shift DAT into shift register bit DATA_WIDTH-1, set bit counter to DATA_WIDTH-2, and go to SHIFT.
- SHIFT: on each bclk_rise, shift DAT in MSB-first and decrement the counter.
  - On the bclk_rise that captures the bit with counter = 0 (LSB), go to DONE.
  - If LRCK = 1 on any SHIFT bclk_rise, discard the partial frame, pulse frame_err, and go to ARM. That edge is treated as a new frame strobe; its DAT bit is not stored.
- DONE (exactly one clk): load data from the shift register and set data_valid = 1. If data_valid was already 1 and data_ack = 0 that cycle, set overrun. Then go to IDLE.
- Handshake: data_ack = 1 while data_valid = 1 clears data_valid on the next clk. data holds its value until the next DONE. data_ack while data_valid = 0 is ignored.
- DONE coinciding with data_ack = 1: new data loads, data_valid stays 1, overrun is not set.
- IDLE with LRCK = 1 on the same BCLK that would be the DONE bit: not applicable. LRCK is evaluated only in IDLE or SHIFT. An LRCK pulse arriving during the single DONE clk is caught at the next bclk_rise only if it is still high.
- Counter width: clog2(DATA_WIDTH). Counter wrap below 0 is unreachable because SHIFT exits at 0.

## Timing
- Reset (rst = 0 at a clk edge) applies to the state, counter, shift register and synchronizers. Reset values: data = 0, data_valid = 0, overrun = 0, frame_err = 0, state = IDLE.
- Reset mid-frame aborts the frame. No data_valid is produced for it.
- bclk_rise lags the pin edge by SYNC_STAGES+1 clk, ±1 for phase.
- data_valid rises 1 clk after the bclk_rise that captures the LSB (the DONE cycle).
- Frame throughput: one frame per LRCK period. The consumer must ack within one frame period, or overrun sets.
- BCLK high and low phases must each last ≥ SYNC_STAGES+1 clk periods (BCLK ≤ 8 MHz at the defaults). Codec BCLK 3.072 MHz is in spec.
- DAT setup/hold relative to the BCLK pin edge must exceed 1 clk period. Codec output changes on BCLK falling edges, which gives ≥ 150 ns of margin.

## Test plan
- Reset: hold rst = 0 for 4 clk with BCLK toggling -> data = 0, data_valid = 0, overrun = 0, frame_err = 0. No valid until after the first LRCK pulse.
- Single frame: LRCK pulse, then 32 bits of 0xA5C3_1E7F at BCLK 3.072 MHz -> data = 0xA5C31E7F. data_valid rises exactly 1 clk after the LSB bclk_rise and stays high until data_ack is pulsed. Cleared the next clk.
- Back-to-back with ack: frames 0x0001_8000 then 0xFFFF_0000, with data_ack asserted on the same clk as the second DONE -> data = 0xFFFF0000, data_valid stays 1, overrun = 0.
- Overrun: two frames with no ack -> data = second frame, overrun = 1 and stays 1 after a later ack, until reset.
- Mid-frame resync: LRCK pulse after 10 bits, then a full frame 0x1234_5678 -> one frame_err pulse, data = 0x12345678. No valid for the partial frame.
- Reset mid-frame: rst = 0 for 1 clk after 20 bits, then a fresh frame 0xDEAD_BEEF -> no valid for the aborted frame, data = 0xDEADBEEF afterwards.

Source files
------------

// File: rtl/audio_adc_rx.sv
// Deserializes codec ADC frames (MSB first, LRCK strobe one BCLK before MSB) in the clk domain.
// data_valid rises one clk after the LSB bclk_rise; holds until data_ack, unacked frame replaced sets overrun.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic                    bclk_prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sr_q, sr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    ferr_q, ferr_d;

  logic bclk_s, lrck_s, dat_s, bclk_rise;

  // Equal-depth chains keep BCLK, LRCK and DAT mutually aligned after synchronization.
  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign dat_s     = dat_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = 1'b0;

    if (valid_q && data_ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bclk_rise && lrck_s) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (bclk_rise) begin
          sr_d[DATA_WIDTH-1] = dat_s;
          cnt_d              = CW'(DATA_WIDTH - 2);
          state_d            = SHIFT;
        end
      end
      SHIFT: begin
        if (bclk_rise) begin
          // LRCK mid-frame is a fresh strobe: its DAT bit belongs to no frame.
          if (lrck_s) begin
            ferr_d  = 1'b1;
            state_d = ARM;
          end else begin
            sr_d[cnt_q] = dat_s;
            if (cnt_q == '0) begin
              state_d = DONE;
            end else begin
              cnt_d = cnt_q - CW'(1);
            end
          end
        end
      end
      DONE: begin
        data_d  = sr_q;
        valid_d = 1'b1;
        if (valid_q && !data_ack) begin
          overrun_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_prev_q <= bclk_s;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed frames at ~3.07 MHz BCLK (16/17-clk bit periods); a monitor scoreboards every presented frame.
`timescale 1ns/1ps
module tb_audio_adc_rx;

  logic        clk;
  logic        rst;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic        data_ack;
  logic [31:0] data;
  logic        data_valid;
  logic        overrun;
  logic        frame_err;

  int          n_pass  = 0;
  int          n_total = 0;
  int          bit_n   = 0;
  int          ferr_cnt = 0;
  int          ferr_base;
  logic [31:0] exp_q[$];
  logic        vld_prev = 1'b0;
  logic [31:0] data_prev = '0;

  audio_adc_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .AUD_BCLK   (AUD_BCLK),
    .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT (AUD_ADCDAT),
    .data_ack   (data_ack),
    .data       (data),
    .data_valid (data_valid),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every new presentation (valid rising, or data replaced while valid) pops one expected frame.
  always @(negedge clk) begin
    if (data_valid && (!vld_prev || data !== data_prev)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_frame: got 0x%08h expected none", data);
      end else begin
        check("frame_data", data, exp_q.pop_front());
      end
    end
    if (frame_err) ferr_cnt++;
    vld_prev  = data_valid;
    data_prev = data;
  end

  // One BCLK period, called at a clk negedge. mode 1: latency check after rise; mode 2: ack in DONE clk.
  task automatic bclk_cycle(input logic lrck, input logic dat, input int mode);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lrck;
    AUD_ADCDAT  = dat;
    repeat ((bit_n % 4 == 3) ? 9 : 8) @(negedge clk);
    bit_n++;
    AUD_BCLK = 1'b1;
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1 check("valid_before_done", {31'd0, data_valid}, 32'd0);
      @(posedge clk);
      #1 check("valid_after_done", {31'd0, data_valid}, 32'd1);
      repeat (5) @(negedge clk);
    end else if (mode == 2) begin
      repeat (3) @(negedge clk);
      data_ack = 1'b1;
      @(negedge clk);
      data_ack = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] v, input int last_mode);
    exp_q.push_back(v);
    bclk_cycle(1'b1, 1'b0, 0);
    for (int i = 31; i >= 0; i--) bclk_cycle(1'b0, v[i], (i == 0) ? last_mode : 0);
  endtask

  task automatic send_partial(input int nbits);
    bclk_cycle(1'b1, 1'b0, 0);
    for (int i = 0; i < nbits; i++) bclk_cycle(1'b0, 1'b1, 0);
  endtask

  task automatic do_ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("valid_cleared_by_ack", {31'd0, data_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0; data_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      AUD_BCLK = ~AUD_BCLK;
    end
    check("rst_data", data, 32'd0);
    check("rst_valid", {31'd0, data_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    AUD_BCLK = 1'b0;
    repeat (3) bclk_cycle(1'b0, 1'b0, 0);
    check("no_valid_without_lrck", {31'd0, data_valid}, 32'd0);

    // Single frame with exact valid latency, hold, and ack clear.
    send_frame(32'hA5C3_1E7F, 1);
    repeat (2) bclk_cycle(1'b0, 1'b0, 0);
    check("single_valid_held", {31'd0, data_valid}, 32'd1);
    do_ack();
    check("single_data_held", data, 32'hA5C3_1E7F);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    check("ack_when_idle_ignored", {31'd0, data_valid}, 32'd0);
    check("no_overrun_single", {31'd0, overrun}, 32'd0);

    // Back-to-back, second DONE coincides with ack.
    send_frame(32'h0001_8000, 0);
    send_frame(32'hFFFF_0000, 2);
    bclk_cycle(1'b0, 1'b0, 0);
    check("b2b_data", data, 32'hFFFF_0000);
    check("b2b_valid", {31'd0, data_valid}, 32'd1);
    check("b2b_no_overrun", {31'd0, overrun}, 32'd0);
    do_ack();

    // Overrun: two frames with no ack.
    send_frame(32'h1357_9BDF, 0);
    send_frame(32'h2468_ACE0, 0);
    bclk_cycle(1'b0, 1'b0, 0);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_data", data, 32'h2468_ACE0);
    do_ack();
    check("ovr_sticky_after_ack", {31'd0, overrun}, 32'd1);

    // Mid-frame LRCK after 10 bits restarts capture.
    ferr_base = ferr_cnt;
    send_partial(10);
    send_frame(32'h1234_5678, 0);
    bclk_cycle(1'b0, 1'b0, 0);
    check("resync_ferr_pulses", ferr_cnt - ferr_base, 32'd1);
    check("resync_data", data, 32'h1234_5678);
    do_ack();
    check("ovr_sticky_resync", {31'd0, overrun}, 32'd1);

    // Reset after 20 bits aborts the frame.
    ferr_base = ferr_cnt;
    send_partial(20);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_data", data, 32'd0);
    check("midrst_valid", {31'd0, data_valid}, 32'd0);
    check("midrst_overrun", {31'd0, overrun}, 32'd0);
    send_frame(32'hDEAD_BEEF, 0);
    bclk_cycle(1'b0, 1'b0, 0);
    check("post_rst_data", data, 32'hDEAD_BEEF);
    check("post_rst_valid", {31'd0, data_valid}, 32'd1);
    check("post_rst_no_ferr", ferr_cnt - ferr_base, 32'd0);
    do_ack();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
